// File: rtl/pipe_stage_reg.sv
// Purpose: inter-stage pipeline register, valid/ready handshake, optional 2-entry skid, flush, bubble-masked ctrl.
// Latency: 1 cycle from accept to out_*; 1 entry/cycle sustained with out_ready high in both modes.
// Backpressure: SKID_EN=1 registers in_ready (one in-flight entry lands in skid); SKID_EN=0 in_ready follows out_ready combinationally.
//
// Ports:
//   clk, reset_n          rising-edge clock, async active-low reset
//   flush_i               synchronous squash of every held entry, blocks accept that cycle
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data upstream control bits and payload
//   out_valid/out_ready   downstream handshake; out_ctrl (zero on bubble), out_data (stale on bubble)
//   out_count             number of entries held (0..2)
module pipe_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 4,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_count
);

   // Main entry M: always the one presented downstream.
   logic              r_m_vld;
   logic [CTRL_W-1:0] r_m_ctrl;
   logic [DATA_W-1:0] r_m_data;

   logic w_s_vld;
   logic w_accept;
   logic w_consume;

   assign w_accept  = in_valid & in_ready;
   assign w_consume = r_m_vld & out_ready;

   generate
      if (SKID_EN) begin : g_skid
         // Skid entry S catches the one entry accepted in the cycle out_ready drops.
         logic              r_s_vld;
         logic [CTRL_W-1:0] r_s_ctrl;
         logic [DATA_W-1:0] r_s_data;

         // Only flush is combinational here; no out_ready -> in_ready path.
         assign in_ready = ~r_s_vld & ~flush_i;
         assign w_s_vld  = r_s_vld;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_m_vld  <= 1'b0;
               r_m_ctrl <= '0;
               r_m_data <= '0;
               r_s_vld  <= 1'b0;
               r_s_ctrl <= '0;
               r_s_data <= '0;
            end else if (flush_i) begin
               r_m_vld <= 1'b0;
               r_s_vld <= 1'b0;
            end else if (r_s_vld) begin
               // Full: in_ready is low, so only a consume can move things (S shifts into M).
               if (w_consume) begin
                  r_m_ctrl <= r_s_ctrl;
                  r_m_data <= r_s_data;
                  r_s_vld  <= 1'b0;
               end
            end else if (w_accept) begin
               if (!r_m_vld || w_consume) begin
                  r_m_vld  <= 1'b1;
                  r_m_ctrl <= in_ctrl;
                  r_m_data <= in_data;
               end else begin
                  r_s_vld  <= 1'b1;
                  r_s_ctrl <= in_ctrl;
                  r_s_data <= in_data;
               end
            end else if (w_consume) begin
               r_m_vld <= 1'b0;
            end
         end
      end else begin : g_noskid
         // A held entry leaving this cycle frees M for a same-cycle accept.
         assign in_ready = (~r_m_vld | out_ready) & ~flush_i;
         assign w_s_vld  = 1'b0;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_m_vld  <= 1'b0;
               r_m_ctrl <= '0;
               r_m_data <= '0;
            end else if (flush_i) begin
               r_m_vld <= 1'b0;
            end else if (w_accept) begin
               r_m_vld  <= 1'b1;
               r_m_ctrl <= in_ctrl;
               r_m_data <= in_data;
            end else if (w_consume) begin
               r_m_vld <= 1'b0;
            end
         end
      end
   endgenerate

   assign out_valid = r_m_vld;
   // Control bits must never leak out of a bubble; data may stay stale.
   assign out_ctrl  = r_m_ctrl & {CTRL_W{r_m_vld}};
   assign out_data  = r_m_data;
   assign out_count = {1'b0, r_m_vld} + {1'b0, w_s_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: self-checking bench for pipe_stage_reg, one skid instance and one single-register instance on shared stimulus.
// Latency: expected entries are queued on model-predicted accepts and popped on each downstream consume.
// Backpressure: the model predicts in_ready and occupancy from its own queue depth, independent of the DUT.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  in_ctrl = '0;
   logic [31:0] in_data = '0;

   logic        ir0, ov0, ir1, ov1;
   logic [3:0]  oc0, oc1;
   logic [31:0] od0, od1;
   logic [1:0]  cnt0, cnt1;

   int errors = 0;
   int checks = 0;
   int acc1   = 0;
   logic [35:0] q0[$];
   logic [35:0] q1[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1'b1)) u_skid (
      .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .out_count(cnt0));

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1'b0)) u_noskid (
      .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .out_count(cnt1));

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One scoreboard step per lane, evaluated at negedge with inputs stable.
   task automatic sb_lane(input int lane, input logic ir, input logic ov,
                          input logic [3:0] oc, input logic [31:0] od, input logic [1:0] cnt);
      int          sz;
      logic        exp_ir;
      logic [35:0] front;
      sz = (lane == 0) ? q0.size() : q1.size();
      if (lane == 0) exp_ir = (sz < 2) && !flush_i;
      else           exp_ir = ((sz == 0) || out_ready) && !flush_i;
      chk($sformatf("L%0d_in_ready", lane), 36'(ir), 36'(exp_ir));
      chk($sformatf("L%0d_count", lane), 36'(cnt), 36'(sz));
      chk($sformatf("L%0d_out_valid", lane), 36'(ov), 36'(sz != 0));
      if (!ov) chk($sformatf("L%0d_bubble_ctrl", lane), 36'(oc), 36'd0);
      if (!flush_i && ov && out_ready && sz != 0) begin
         front = (lane == 0) ? q0[0] : q1[0];
         chk($sformatf("L%0d_order", lane), {oc, od}, front);
         if (lane == 0) void'(q0.pop_front());
         else           void'(q1.pop_front());
      end
      if (flush_i) begin
         if (lane == 0) q0.delete();
         else           q1.delete();
      end else if (in_valid && exp_ir) begin
         if (lane == 0) q0.push_back({in_ctrl, in_data});
         else begin
            q1.push_back({in_ctrl, in_data});
            acc1++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         q0.delete();
         q1.delete();
      end else begin
         sb_lane(0, ir0, ov0, oc0, od0, cnt0);
         sb_lane(1, ir1, ov1, oc1, od1, cnt1);
      end
   end

   task automatic drive(input logic iv, input logic [3:0] c, input logic [31:0] d,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush_i   = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state, no clock edge needed.
      #1 reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 36'(ov0), 36'd0);
      chk("rst_out_ctrl", 36'(oc0), 36'd0);
      chk("rst_out_data", 36'(od0), 36'd0);
      chk("rst_count", 36'(cnt0), 36'd0);
      chk("rst_in_ready", 36'(ir0), 36'd1);
      chk("rst_in_ready1", 36'(ir1), 36'd1);
      tick();
      reset_n = 1'b1;

      // Streaming with out_ready high.
      drive(1'b1, 4'b1010, 32'h11, 1'b1, 1'b0); tick();
      chk("strm_d11", 36'(od0), 36'h11); chk("strm_cnt1", 36'(cnt0), 36'd1);
      drive(1'b1, 4'b1010, 32'h22, 1'b1, 1'b0); tick();
      chk("strm_d22", 36'(od0), 36'h22); chk("strm_cnt2", 36'(cnt0), 36'd1);
      chk("strm_ns_d22", 36'(od1), 36'h22);
      drive(1'b1, 4'b1010, 32'h33, 1'b1, 1'b0); tick();
      chk("strm_d33", 36'(od0), 36'h33); chk("strm_ctrl", 36'(oc0), 36'hA);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("strm_end_vld", 36'(ov0), 36'd0); chk("strm_end_cnt", 36'(cnt0), 36'd0);

      // Stall into the skid entry.
      drive(1'b1, 4'h3, 32'hA, 1'b0, 1'b0); tick();
      chk("stall_cnt1", 36'(cnt0), 36'd1); chk("stall_ir1", 36'(ir0), 36'd1);
      drive(1'b1, 4'h3, 32'hB, 1'b0, 1'b0); tick();
      chk("stall_cnt2", 36'(cnt0), 36'd2); chk("stall_ir0", 36'(ir0), 36'd0);
      chk("stall_holdA", 36'(od0), 36'hA);
      chk("stall_ns_ir", 36'(ir1), 36'd0); chk("stall_ns_cnt", 36'(cnt1), 36'd1);
      drive(1'b1, 4'h3, 32'hD, 1'b0, 1'b0); tick();
      chk("stall_full_cnt", 36'(cnt0), 36'd2); chk("stall_full_A", 36'(od0), 36'hA);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("drain_B", 36'(od0), 36'hB); chk("drain_cnt", 36'(cnt0), 36'd1);
      tick();
      chk("drain_vld", 36'(ov0), 36'd0); chk("drain_ctrl", 36'(oc0), 36'd0);

      // Flush with two entries held and a competing input.
      drive(1'b1, 4'h5, 32'h5, 1'b0, 1'b0); tick();
      drive(1'b1, 4'h6, 32'h6, 1'b0, 1'b0); tick();
      chk("fl_pre_cnt", 36'(cnt0), 36'd2);
      drive(1'b1, 4'h7, 32'hC, 1'b0, 1'b1); #1;
      chk("fl_ir_during", 36'(ir0), 36'd0); chk("fl_ir1_during", 36'(ir1), 36'd0);
      tick();
      chk("fl_cnt", 36'(cnt0), 36'd0); chk("fl_vld", 36'(ov0), 36'd0);
      chk("fl_cnt1", 36'(cnt1), 36'd0);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0); #1;
      chk("fl_ir_after", 36'(ir0), 36'd1);
      tick();
      chk("fl_noC", 36'(ov0), 36'd0);

      // Bubbles between ctrl=1111 entries.
      drive(1'b1, 4'hF, 32'h77, 1'b1, 1'b0); tick();
      chk("bub_ctrl_in", 36'(oc0), 36'hF); chk("bub_d77", 36'(od0), 36'h77);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'hF, 32'h99, 1'b1, 1'b0); tick();
         chk("bub_gap_ctrl", 36'(oc0), 36'd0); chk("bub_gap_data", 36'(od0), 36'h77);
         chk("bub_gap_ctrl1", 36'(oc1), 36'd0);
      end
      drive(1'b1, 4'hF, 32'h88, 1'b1, 1'b0); tick();
      chk("bub_ctrl_next", 36'(oc0), 36'hF); chk("bub_d88", 36'(od0), 36'h88);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0); tick();

      // Asynchronous reset with two entries held.
      drive(1'b1, 4'h2, 32'h31, 1'b0, 1'b0); tick();
      drive(1'b1, 4'h2, 32'h32, 1'b0, 1'b0); tick();
      chk("ar_pre_cnt", 36'(cnt0), 36'd2);
      drive(1'b1, 4'h2, 32'h33, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_vld", 36'(ov0), 36'd0); chk("ar_ctrl", 36'(oc0), 36'd0);
      chk("ar_data", 36'(od0), 36'd0); chk("ar_cnt", 36'(cnt0), 36'd0);
      chk("ar_ir", 36'(ir0), 36'd1); chk("ar_vld1", 36'(ov1), 36'd0);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      chk("ar_post_vld", 36'(ov0), 36'd0); chk("ar_post_vld1", 36'(ov1), 36'd0);

      // Random traffic on both instances until the single-register lane accepts 1000 entries.
      for (int cyc = 0; cyc < 20000 && acc1 < 1000; cyc++) begin
         drive($urandom_range(0, 9) < 7, 4'($urandom), $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 63) == 0);
         tick();
      end
      chk("rand_entries", 36'(acc1 >= 1000), 36'd1);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
      repeat (4) tick();
      chk("rand_drain0", 36'(q0.size()), 36'd0);
      chk("rand_drain1", 36'(q1.size()), 36'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, an optional skid buffer, synchronous flush and bubble-safe control bits. It replaces the fixed-field, always-advancing stage registers between the pipeline stages (for example M→W) and lets a stage stall or squash without corrupting downstream state. Control bits such as RegWrite, MemtoReg and PCSrc travel on `in_ctrl` and are forced to 0 whenever the stage holds a bubble. Data fields travel on `in_data`.

## Interface
- `DATA_W`, default 32: payload width. Concatenate ALUResult, ReadData, Rd and similar fields into this bus.
- `CTRL_W`, default 4: control-bit width. These bits are zeroed on every bubble.
- `SKID_EN`, default 1: 1 gives a 2-entry skid buffer with registered `in_ready`. 0 gives a single register with combinational `in_ready`.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts the entry.
- `out_ctrl`  out  CTRL_W  control bits. Equals 0 whenever `out_valid`=0.
- `out_data`  out  DATA_W  payload.
- `out_count`  out  2  entries held (0..2).

## Operation
Storage:
- Main entry M: valid, ctrl, data. M drives all out_* ports.
- Skid entry S: valid, ctrl, data. S exists only when SKID_EN=1.

Handshake events:
- Accept = `in_valid & in_ready`.
- Consume = `out_valid & out_ready`.

Reset (`reset_n`=0):
- M and S are cleared, including ctrl and data.
- `out_valid`=0, `out_ctrl`=0, `out_data`=0, `out_count`=0.
- `in_ready`=1 immediately; no clock is required.

SKID_EN=1 state machine, with state = `out_count`:
- `in_ready` = !S.valid & !flush_i.
- EMPTY:
  - accept → ONE; M←in.
  - otherwise hold.
- ONE:
  - accept & consume → ONE; M←in.
  - accept & !consume → TWO; S←in.
  - consume only → EMPTY.
  - neither → hold.
- TWO (`in_ready`=0):
  - consume → ONE; M←S.
  - otherwise hold. M is stable while `out_ready`=0.

SKID_EN=0:
- `in_ready` = (!M.valid | out_ready) & !flush_i.
- Accept → M←in; else consume → EMPTY.
- `out_count` never exceeds 1.

Common rules:
- `flush_i`=1 has highest priority over accept and consume. At the next edge all entries are invalidated and `out_count`→0. No entry is accepted in the flush cycle.
- Data registers keep their stale value when invalid. `out_ctrl` is masked by `out_valid`.
- Order is strictly FIFO and entries are never duplicated. A valid M with `out_ready`=0 holds ctrl and data unchanged.
- Reset asserted mid-transfer discards all entries asynchronously. No entry is delivered after `reset_n` rises unless a new one is accepted.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle with `out_ready` held high, in both modes.
- SKID_EN=1: `in_ready`, `out_valid`, `out_ctrl`, `out_data` and `out_count` are pure register outputs. The only combinational term is the `flush_i` gating of `in_ready`. No out_ready→in_ready path exists.
- SKID_EN=0: `out_ready`→`in_ready` is combinational, and the path length is the caller's responsibility.
- Backpressure (SKID_EN=1): `out_ready` falling at edge N may still see one accept at N. `in_ready` falls after that edge. The entry lands in S and nothing is lost.

## Test plan
- **Reset:** drive `reset_n`=0 mid-stream with `out_count`=2 → outputs go to 0 without a clock edge and `in_ready`=1. After release, no stale entry appears.
- **Streaming:** `out_ready`=1, feed data 0x11,0x22,0x33 with ctrl 4'b1010 on consecutive cycles → same sequence out one cycle later, no gaps, `out_count`=1 throughout.
- **Stall/skid (SKID_EN=1):** hold `out_ready`=0 and push A=0xA, B=0xB → `out_count`=2, `in_ready`=0, output holds A. Release → A then B on consecutive cycles, then `out_valid`=0 and `out_ctrl`=0.
- **Flush:** with 2 entries held, pulse `flush_i` for one cycle while `in_valid`=1 with data 0xC → `out_count`=0 next cycle and 0xC is never delivered. `in_ready`=0 during the pulse and 1 after.
- **Bubble control:** `in_valid`=0 for 3 cycles between entries carrying ctrl 4'b1111 → `out_ctrl`=0 in the gap cycles, while `out_data` retains its last value.
- **SKID_EN=0:** random valid/ready traffic on 1000 entries → output sequence matches a scoreboard, `out_count`≤1, and `in_ready` equals !M.valid|out_ready on every cycle.
